// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave.
// Holds the AXI response encodings, the write/read FSM state enums, the
// register-map slot constants and helpers that map a word slot to the
// response code its write or read access returns.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

    localparam int NUM_RW_REGS = 4;
    localparam int STATUS_SLOT = 4;
    localparam int SLOT_IDX_W  = 3;

    // Slots 0-3 are writable, the status slot rejects writes, the rest are holes.
    function automatic resp_t write_resp(input logic [SLOT_IDX_W-1:0] idx);
        if (int'(idx) < NUM_RW_REGS) begin
            return RESP_OKAY;
        end else if (int'(idx) == STATUS_SLOT) begin
            return RESP_SLVERR;
        end
        return RESP_DECERR;
    endfunction

    // Slots 0-4 are readable, the rest are holes.
    function automatic resp_t read_resp(input logic [SLOT_IDX_W-1:0] idx);
        if (int'(idx) <= STATUS_SLOT) begin
            return RESP_OKAY;
        end
        return RESP_DECERR;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R) with the standard
// signal names. The slave modport is used by axi4_lite_reg_slave, the
// master modport by whatever drives the bus.
interface axi4_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;

    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;

    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;

    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;

    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axi4_lite_strb_merge.sv
// Byte-strobe merge.
// Ports: old_word (current register value), new_word (write data),
// strb (one bit per byte lane), merged_word (new byte where strb is set,
// old byte otherwise). Purely combinational.
module axi4_lite_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged_word
);

    for (genvar gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_lane
        assign merged_word[gi*8 +: 8] = strb[gi] ? new_word[gi*8 +: 8] : old_word[gi*8 +: 8];
    end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register slave with 8 word slots.
// Ports: S_AXI_ACLK (clock), S_AXI_ARESET (async active-high reset),
// s_axi (AXI4-Lite slave bus), reg_out (contents of RW slots 0-3),
// reg_wr_pulse (one-cycle strobe per RW slot on a committed write),
// status_in (value returned for the read-only status slot 4).
// Slots 5-7 are unmapped and answer DECERR. The write and read paths are
// independent FSMs so neither ever stalls the other.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                                          S_AXI_ACLK,
    input  logic                                          S_AXI_ARESET,
    axi4_lite_reg_slave_if.slave                          s_axi,
    output logic [NUM_RW_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_RW_REGS-1:0]                        reg_wr_pulse,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                 status_in
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // Keeps every READY low while reset is held and raises them on the
    // first edge after release.
    logic ready_en_reg;
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) ready_en_reg <= 1'b0;
        else              ready_en_reg <= 1'b1;
    end

    // ---------------------------------------------------------------- write
    w_state_t              w_state_reg, w_state_next;
    logic                  aw_held_reg;
    logic [SLOT_IDX_W-1:0] aw_idx_reg;
    logic                  w_held_reg;
    logic [DW-1:0]         w_data_reg;
    logic [SW-1:0]         w_strb_reg;
    resp_t                 bresp_reg;

    logic                  aw_ready, w_ready, b_valid;
    logic                  aw_hs, w_hs, b_hs, wr_commit;
    logic [SLOT_IDX_W-1:0] wr_idx;
    logic [DW-1:0]         wr_data;
    logic [SW-1:0]         wr_strb;
    logic [NUM_RW_REGS-1:0] wr_sel;

    logic [DW-1:0]         regs_reg [NUM_RW_REGS];
    logic [DW-1:0]         merged   [NUM_RW_REGS];
    logic [NUM_RW_REGS-1:0] pulse_reg;

    assign aw_hs = s_axi.S_AXI_AWVALID & aw_ready;
    assign w_hs  = s_axi.S_AXI_WVALID  & w_ready;
    assign b_hs  = b_valid & s_axi.S_AXI_BREADY;

    // A channel arriving this cycle bypasses its holding register so the
    // commit happens in the same cycle as the second of the two handshakes.
    assign wr_idx  = aw_held_reg ? aw_idx_reg : s_axi.S_AXI_AWADDR[4:2];
    assign wr_data = w_held_reg  ? w_data_reg : s_axi.S_AXI_WDATA;
    assign wr_strb = w_held_reg  ? w_strb_reg : s_axi.S_AXI_WSTRB;
    assign wr_commit = (w_state_reg == W_IDLE) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) w_state_reg <= W_IDLE;
        else              w_state_reg <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (wr_commit)            w_state_next = W_RESP;
            W_RESP:  if (s_axi.S_AXI_BREADY)   w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                aw_ready = ready_en_reg && !aw_held_reg;
                w_ready  = ready_en_reg && !w_held_reg;
            end
            W_RESP:  b_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_held_reg <= 1'b0;
            aw_idx_reg  <= '0;
            w_held_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
        end else if (b_hs) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= s_axi.S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                w_data_reg <= s_axi.S_AXI_WDATA;
                w_strb_reg <= s_axi.S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET)   bresp_reg <= RESP_OKAY;
        else if (wr_commit) bresp_reg <= write_resp(wr_idx);
    end

    for (genvar gi = 0; gi < NUM_RW_REGS; gi++) begin : g_rw
        axi4_lite_strb_merge #(
            .DATA_WIDTH (DW)
        ) u_merge (
            .old_word    (regs_reg[gi]),
            .new_word    (wr_data),
            .strb        (wr_strb),
            .merged_word (merged[gi])
        );
        assign wr_sel[gi]  = wr_commit && (wr_idx == SLOT_IDX_W'(gi));
        assign reg_out[gi] = regs_reg[gi];
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_RW_REGS; i++) regs_reg[i] <= '0;
            pulse_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                if (wr_sel[i]) regs_reg[i] <= merged[i];
            end
            pulse_reg <= wr_sel;
        end
    end

    assign reg_wr_pulse        = pulse_reg;
    assign s_axi.S_AXI_AWREADY = aw_ready;
    assign s_axi.S_AXI_WREADY  = w_ready;
    assign s_axi.S_AXI_BVALID  = b_valid;
    assign s_axi.S_AXI_BRESP   = bresp_reg;

    // ----------------------------------------------------------------- read
    r_state_t              r_state_reg, r_state_next;
    logic                  ar_ready, r_valid, ar_hs;
    logic [SLOT_IDX_W-1:0] rd_idx;
    logic [DW-1:0]         rd_word;
    logic [DW-1:0]         rdata_reg;
    resp_t                 rresp_reg;

    assign rd_idx = s_axi.S_AXI_ARADDR[4:2];
    assign ar_hs  = s_axi.S_AXI_ARVALID & ar_ready;

    // Reads sample the register array before the edge, so a read that
    // coincides with a write commit to the same slot returns the old value.
    always_comb begin
        rd_word = '0;
        if (int'(rd_idx) < NUM_RW_REGS)       rd_word = regs_reg[rd_idx[1:0]];
        else if (int'(rd_idx) == STATUS_SLOT) rd_word = status_in;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) r_state_reg <= R_IDLE;
        else              r_state_reg <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_hs)              r_state_next = R_RESP;
            R_RESP:  if (s_axi.S_AXI_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        case (r_state_reg)
            R_IDLE:  ar_ready = ready_en_reg;
            R_RESP:  r_valid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rdata_reg <= '0;
            rresp_reg <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_reg <= rd_word;
            rresp_reg <= read_resp(rd_idx);
        end
    end

    assign s_axi.S_AXI_ARREADY = ar_ready;
    assign s_axi.S_AXI_RVALID  = r_valid;
    assign s_axi.S_AXI_RDATA   = rdata_reg;
    assign s_axi.S_AXI_RRESP   = rresp_reg;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed testbench for axi4_lite_reg_slave.
// Drives the AXI4-Lite bus through the interface, compares every response
// against hand-computed values and prints one line per bus transaction.
module tb_axi4_lite_reg_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0][31:0] reg_out;
    logic [3:0]       reg_wr_pulse;
    logic [31:0]      status_in;

    axi4_lite_reg_slave_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    axi4_lite_reg_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axi        (bus),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse),
        .status_in    (status_in)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_cnt [4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) pulse_cnt[i] <= pulse_cnt[i] + int'(reg_wr_pulse[i]);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full write; returns BRESP and per-slot pulse counts (2 bits per slot).
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [7:0] pd);
        int  pc0 [4];
        bit  aw_done, w_done, aw_hs, w_hs;
        int  n;
        for (int i = 0; i < 4; i++) pc0[i] = pulse_cnt[i];
        bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge clk); #1; n++;
            if (aw_hs) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.S_AXI_WVALID  = 1'b0; end
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        check_eq("wr_handshake", {aw_done, w_done}, 2'b11);
        n = 0;
        while (!bus.S_AXI_BVALID && n < 50) begin @(posedge clk); #1; n++; end
        check_eq("wr_bvalid", bus.S_AXI_BVALID, 1'b1);
        resp = bus.S_AXI_BRESP;
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 4; i++) pd[2*i +: 2] = 2'(pulse_cnt[i] - pc0[i]);
        $display("[TB] WR addr=0x%02h data=0x%08h strb=0x%h resp=%0d pulses=0x%02h", addr, data, strb, resp, pd);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ar_done, ar_hs;
        int n;
        bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
        ar_done = 0; n = 0;
        while (!ar_done && n < 50) begin
            ar_hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
            @(posedge clk); #1; n++;
            if (ar_hs) ar_done = 1;
        end
        bus.S_AXI_ARVALID = 1'b0;
        check_eq("rd_handshake", ar_done, 1'b1);
        n = 0;
        while (!bus.S_AXI_RVALID && n < 50) begin @(posedge clk); #1; n++; end
        check_eq("rd_rvalid", bus.S_AXI_RVALID, 1'b1);
        data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
        bus.S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_RREADY = 1'b0;
        $display("[TB] RD addr=0x%02h data=0x%08h resp=%0d", addr, data, resp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [7:0]  pd;
        logic [7:0]  exp_pd;
        logic [31:0] rd;

        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        status_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_handshake", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                                   bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 5'b00000);
        check_eq("rst_resp_rdata", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, 36'h0);
        check_eq("rst_regs", reg_out, 128'h0);
        check_eq("rst_pulse", reg_wr_pulse, 4'h0);
        rst = 1'b0;
        #1;
        check_eq("rel_ready_pre", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        @(posedge clk); #1;
        check_eq("rel_ready_post", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

        // Basic writes and read-back of slots 0-3
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp, pd);
            exp_pd = 8'h01 << (2 * i);
            check_eq($sformatf("wr%0d_resp", i), resp, 2'b00);
            check_eq($sformatf("wr%0d_pulse", i), pd, exp_pd);
        end
        check_eq("regs_after_wr", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), rd, resp);
            check_eq($sformatf("rd%0d_data", i), rd, 32'(i + 1));
            check_eq($sformatf("rd%0d_resp", i), resp, 2'b00);
        end

        // AW three cycles ahead of W, partial strobe, then BREADY held off
        bus.S_AXI_AWADDR = 5'h04; bus.S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        check_eq("split_aw_taken", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}, 3'b010);
        repeat (2) @(posedge clk);
        #1;
        check_eq("split_waiting", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, reg_out[1]},
                 {3'b010, 32'h2});
        bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'h5; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_WVALID = 1'b0;
        check_eq("split_bvalid", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, 3'b100);
        check_eq("split_merge", reg_out[1], 32'h00AD00EF);
        check_eq("split_pulse", reg_wr_pulse, 4'b0010);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_eq($sformatf("bhold%0d", c),
                     {bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, reg_wr_pulse},
                     {5'b10000, 4'b0000});
        end
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        check_eq("b_release", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b011);
        $display("[TB] WR addr=0x04 data=0xdeadbeef strb=0x5 split AW/W, BREADY delayed");

        // Status slot and unmapped slots
        status_in = 32'hCAFE0001;
        axi_read(5'h10, rd, resp);
        check_eq("status_rd", {rd, resp}, {32'hCAFE0001, 2'b00});
        axi_write(5'h10, 32'h12345678, 4'hF, resp, pd);
        check_eq("status_wr_resp", resp, 2'b10);
        check_eq("status_wr_pulse", pd, 8'h00);
        check_eq("status_wr_regs", reg_out, {32'h4, 32'h3, 32'h00AD00EF, 32'h1});
        axi_read(5'h18, rd, resp);
        check_eq("unmapped_rd", {rd, resp}, {32'h0, 2'b11});
        axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, resp, pd);
        check_eq("unmapped_wr", {resp, pd}, {2'b11, 8'h00});
        check_eq("unmapped_wr_regs", reg_out, {32'h4, 32'h3, 32'h00AD00EF, 32'h1});

        // Zero strobe still acknowledges and pulses, upper-lane partial write
        axi_write(5'h00, 32'hFFFFFFFF, 4'h0, resp, pd);
        check_eq("strb0_resp_pulse", {resp, pd}, {2'b00, 8'h01});
        check_eq("strb0_data", reg_out[0], 32'h1);
        axi_write(5'h0C, 32'hAABBCCDD, 4'hA, resp, pd);
        check_eq("strbA_resp_pulse", {resp, pd}, {2'b00, 8'h40});
        check_eq("strbA_data", reg_out[3], 32'hAA00CC04);

        // Read and write of the same slot on the same edge
        bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 5'h08;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        check_eq("coll_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        check_eq("coll_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b11);
        check_eq("coll_rdata", {bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_BRESP}, {32'h3, 4'b0000});
        check_eq("coll_reg", reg_out[2], 32'h55);
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        check_eq("coll_done", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        $display("[TB] WR+RD addr=0x08 same edge, old data returned");
        axi_read(5'h08, rd, resp);
        check_eq("coll_after", {rd, resp}, {32'h55, 2'b00});

        // Reset between AW and W handshakes aborts the write
        bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        check_eq("abort_aw_taken", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b01);
        bus.S_AXI_WDATA = 32'h77; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("abort_async", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                                 bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 5'b00000);
        check_eq("abort_regs", reg_out, 128'h0);
        @(posedge clk); #1;
        bus.S_AXI_WVALID = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("abort_ready_pre", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        @(posedge clk); #1;
        check_eq("abort_ready_post", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_eq($sformatf("abort_idle%0d", c), {bus.S_AXI_BVALID, reg_out[0]}, 33'h0);
        end
        $display("[TB] WR addr=0x00 data=0x77 aborted by reset");
        axi_write(5'h00, 32'h77, 4'hF, resp, pd);
        check_eq("post_abort_wr", {resp, pd, reg_out[0]}, {2'b00, 8'h01, 32'h77});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi4_lite_reg_slave.md
AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte-address width giving 8 word slots.
REQ-003 S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-004 S_AXI_ARESET  in  1  reset, asynchronous, active-high.
REQ-005 S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write address channel.
REQ-006 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1  write data channel.
REQ-007 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write response channel.
REQ-008 S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  read address channel.
REQ-009 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read data channel.
REQ-010 reg_out  out  4x32  current contents of RW registers 0-3.
REQ-011 reg_wr_pulse  out  4  one-cycle strobe per RW register on a committed write.
REQ-012 status_in  in  32  sampled value returned for read-only slot 4.

Function
REQ-013 Word index = ADDR[4:2]; ADDR[1:0] ignored; slots 0-3 RW, slot 4 RO (status_in), slots 5-7 unmapped.
REQ-014 Write FSM states: W_IDLE, W_RESP; AW and W captured independently into one-entry holding registers.
REQ-015 In W_IDLE, AWREADY=1 while no address held, WREADY=1 while no data held; both 0 in W_RESP.
REQ-016 When both address and data are held (same or different cycles), the write SHALL commit that cycle and FSM moves to W_RESP; BVALID=1 next cycle.
REQ-017 Commit to slot 0-3 SHALL update byte lane n only where WSTRB[n]=1, pulse reg_wr_pulse[idx] for exactly one cycle, BRESP=OKAY(00); WSTRB=0 still gives OKAY and pulse, data unchanged.
REQ-018 Write to slot 4 SHALL change nothing, no pulse, BRESP=SLVERR(10); slots 5-7 BRESP=DECERR(11), no change.
REQ-019 BVALID/BRESP SHALL hold stable until BREADY=1; on handshake, holding registers clear and FSM returns to W_IDLE (AWREADY/WREADY high next cycle).
REQ-020 Read FSM states: R_IDLE, R_RESP; ARREADY=1 only in R_IDLE.
REQ-021 On AR handshake, RDATA SHALL be loaded from the addressed slot's value before that cycle's edge, RVALID=1 next cycle (1-cycle latency).
REQ-022 RRESP: OKAY for slots 0-4, DECERR for 5-7 with RDATA=0; RDATA/RRESP/RVALID stable until RREADY=1, then R_IDLE.
REQ-023 Simultaneous read and write commit to same slot: read returns pre-write value.
REQ-024 Read and write paths SHALL operate concurrently without mutual stalling.

Reset
REQ-025 On S_AXI_ARESET=1, immediately: all READY/VALID outputs 0, BRESP=RRESP=00, RDATA=0, registers 0-3=0, reg_wr_pulse=0, holding registers empty, both FSMs idle.
REQ-026 Reset asserted mid-transaction SHALL abort it; no partial register update, no response issued after release.
REQ-027 AWREADY, WREADY, ARREADY SHALL go to 1 on the first rising edge after reset deasserts.

Structure
REQ-028 A shared package axi4_lite_pkg SHALL hold resp encodings (OKAY, SLVERR, DECERR), write/read FSM state enums, and slot index constants (NUM_RW_REGS=4, STATUS_SLOT=4).
REQ-029 Byte-strobe merge SHALL be a sub-module axi4_lite_strb_merge (old word, new word, strobe -> merged word); no other sub-modules.

Verification
REQ-030 Write 0x1,0x2,0x3,0x4 to addr 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1..0x4, all RESP=00, one reg_wr_pulse per write.
REQ-031 AW at cycle t, W at t+3 (addr 0x4, data 0xDEADBEEF, WSTRB=0x5) with reg1=0x2 -> reg_out[1]=0x00AD00EF, BVALID at t+4.
REQ-032 Hold BREADY=0 for 5 cycles after BVALID -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout.
REQ-033 status_in=0xCAFE0001, read 0x10 -> RDATA 0xCAFE0001 OKAY; write 0x10 -> BRESP=10; read 0x18 -> RDATA 0, RRESP=11.
REQ-034 Same-cycle read and write of addr 0x8 (old 0x3, new 0x55) -> RDATA 0x3, subsequent read 0x55.
REQ-035 Assert reset between AW and W handshakes of write 0x77 to 0x0 -> reg_out[0]=0, no BVALID, READYs high one edge after release.
